// File: rtl/uart_pkg.sv
// Shared types and helpers for the oversampling UART receive path.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        BREAK
    } rx_state_t;

    typedef logic [7:0] payload_t;

    // Accumulator step per clock.
    // Clamped to clk_freq so that at most one tick is issued per clock.
    function automatic logic [31:0] calc_tick_inc(
        input int unsigned clk_freq,
        input int unsigned baud_rate,
        input int unsigned oversample
    );
        logic [31:0] inc;
        inc = 32'(baud_rate * oversample);
        if (inc > clk_freq) begin
            inc = clk_freq;
        end
        return inc;
    endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Fractional baud accumulator.
// Issues a one-cycle tick at BAUD_RATE*OVERSAMPLE on average.
module uart_baud_tick
    import uart_pkg::*;
#(
    parameter int unsigned CLK_FREQ   = 1000000,
    parameter int unsigned BAUD_RATE  = 9600,
    parameter int unsigned OVERSAMPLE = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    output logic tick
);

    localparam logic [31:0] INC   = calc_tick_inc(CLK_FREQ, BAUD_RATE, OVERSAMPLE);
    localparam logic [31:0] CLK_W = 32'(CLK_FREQ);

    logic [31:0] acc_q, acc_d, sum;
    logic        tick_q, tick_d;

    // Next accumulator value; the remainder is carried so the phase never drifts.
    always_comb begin
        sum    = acc_q + INC;
        acc_d  = sum;
        tick_d = 1'b0;
        if (clear) begin
            acc_d = '0;
        end else if (sum >= CLK_W) begin
            acc_d  = sum - CLK_W;
            tick_d = 1'b1;
        end
    end

    // Accumulator and tick registers.
    always_ff @(posedge clk) begin
        if (!rst) begin
            acc_q  <= '0;
            tick_q <= 1'b0;
        end else begin
            acc_q  <= acc_d;
            tick_q <= tick_d;
        end
    end

    assign tick = tick_q;

endmodule

// File: rtl/uart_rx_os.sv
// 16x-oversampling 8N1 UART receiver.
// Uses majority voting around mid-bit, and provides framing-error and break detection.
module uart_rx_os
    import uart_pkg::*;
#(
    parameter int unsigned CLK_FREQ   = 1000000,
    parameter int unsigned BAUD_RATE  = 9600,
    parameter int unsigned OVERSAMPLE = 16,
    parameter int unsigned DATA_BITS  = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] doutrx,
    output logic                 donerx,
    output logic                 frame_err,
    output logic                 brk,
    output logic                 busy
);

    localparam int unsigned SW = $clog2(OVERSAMPLE);
    localparam int unsigned BW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
    localparam logic [SW-1:0] S_LO   = SW'(OVERSAMPLE / 2 - 1);
    localparam logic [SW-1:0] S_MID  = SW'(OVERSAMPLE / 2);
    localparam logic [SW-1:0] S_HI   = SW'(OVERSAMPLE / 2 + 1);
    localparam logic [SW-1:0] S_LAST = SW'(OVERSAMPLE - 1);
    localparam logic [BW-1:0] B_LAST = BW'(DATA_BITS - 1);

    rx_state_t            state_q, state_d;
    logic [SW-1:0]        scnt_q, scnt_d;
    logic [BW-1:0]        bcnt_q, bcnt_d;
    logic [1:0]           samp_q, samp_d;
    logic                 bit_q, bit_d;
    logic [DATA_BITS-1:0] shreg_q, shreg_d;
    logic [DATA_BITS-1:0] dout_q, dout_d;
    logic                 done_q, done_d;
    logic                 ferr_q, ferr_d;
    logic                 rx_meta_q, rx_s_q, rx_prev_q;
    logic                 tick, clr, fall, maj, decide;

    uart_baud_tick #(
        .CLK_FREQ  (CLK_FREQ),
        .BAUD_RATE (BAUD_RATE),
        .OVERSAMPLE(OVERSAMPLE)
    ) u_tick (
        .clk  (clk),
        .rst  (rst),
        .clear(clr),
        .tick (tick)
    );

    // Two-flop synchronizer plus a delayed copy for falling-edge detection; resets to idle-high.
    always_ff @(posedge clk) begin
        if (!rst) begin
            rx_meta_q <= 1'b1;
            rx_s_q    <= 1'b1;
            rx_prev_q <= 1'b1;
        end else begin
            rx_meta_q <= rx;
            rx_s_q    <= rx_meta_q;
            rx_prev_q <= rx_s_q;
        end
    end

    // Receiver control: sample counter, majority vote, FSM next state and strobes.
    always_comb begin
        state_d = state_q;
        scnt_d  = scnt_q;
        bcnt_d  = bcnt_q;
        samp_d  = samp_q;
        bit_d   = bit_q;
        shreg_d = shreg_q;
        dout_d  = dout_q;
        done_d  = 1'b0;
        ferr_d  = 1'b0;
        clr     = 1'b0;

        fall   = rx_prev_q & ~rx_s_q;
        maj    = (samp_q[0] & samp_q[1]) | (samp_q[0] & rx_s_q) | (samp_q[1] & rx_s_q);
        decide = tick & (scnt_q == S_HI);

        if (tick) begin
            scnt_d = (scnt_q == S_LAST) ? '0 : scnt_q + 1'b1;
            if (scnt_q == S_LO)  samp_d[0] = rx_s_q;
            if (scnt_q == S_MID) samp_d[1] = rx_s_q;
        end

        case (state_q)
            IDLE: begin
                scnt_d = '0;
                if (fall) begin
                    state_d = START;
                    clr     = 1'b1;
                end
            end
            START: begin
                if (decide) begin
                    if (!maj) begin
                        state_d = DATA;
                        scnt_d  = '0;
                        bcnt_d  = '0;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            DATA: begin
                // The vote is latched mid-bit and shifted in when scnt wraps.
                if (decide) bit_d = maj;
                if (tick && scnt_q == S_LAST) begin
                    shreg_d = {bit_q, shreg_q[DATA_BITS-1:1]};
                    if (bcnt_q == B_LAST) state_d = STOP;
                    else                  bcnt_d  = bcnt_q + 1'b1;
                end
            end
            STOP: begin
                if (decide) begin
                    if (maj) begin
                        dout_d  = shreg_q;
                        done_d  = 1'b1;
                        state_d = IDLE;
                    end else begin
                        ferr_d  = 1'b1;
                        state_d = rx_s_q ? IDLE : BREAK;
                    end
                end
            end
            BREAK: begin
                if (rx_s_q) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Receiver state registers.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
            scnt_q  <= '0;
            bcnt_q  <= '0;
            samp_q  <= '1;
            bit_q   <= 1'b1;
            shreg_q <= '0;
            dout_q  <= '0;
            done_q  <= 1'b0;
            ferr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            scnt_q  <= scnt_d;
            bcnt_q  <= bcnt_d;
            samp_q  <= samp_d;
            bit_q   <= bit_d;
            shreg_q <= shreg_d;
            dout_q  <= dout_d;
            done_q  <= done_d;
            ferr_q  <= ferr_d;
        end
    end

    assign doutrx    = dout_q;
    assign donerx    = done_q;
    assign frame_err = ferr_q;
    assign brk       = (state_q == BREAK);
    assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx_os.sv
// Directed bench for uart_rx_os at 1 MHz clock and 9600 baud.
`timescale 1ns/1ps
module tb_uart_rx_os;

    logic       clk;
    logic       rst;
    logic       rx;
    logic [7:0] doutrx;
    logic       donerx;
    logic       frame_err;
    logic       brk;
    logic       busy;

    uart_rx_os #(
        .CLK_FREQ  (1000000),
        .BAUD_RATE (9600),
        .OVERSAMPLE(16),
        .DATA_BITS (8)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .rx       (rx),
        .doutrx   (doutrx),
        .donerx   (donerx),
        .frame_err(frame_err),
        .brk      (brk),
        .busy     (busy)
    );

    initial clk = 1'b0;
    always #500 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Strobe monitor.
    int         done_cnt = 0;
    int         ferr_cnt = 0;
    int         both_cnt = 0;
    logic [7:0] rxq[$];
    logic       watch    = 1'b0;
    int         low_run  = 0;
    int         max_low  = 0;

    always @(negedge clk) begin
        if (donerx) begin
            done_cnt++;
            rxq.push_back(doutrx);
        end
        if (frame_err) ferr_cnt++;
        if (donerx && frame_err) both_cnt++;
        if (watch) begin
            if (!busy) low_run++;
            else       low_run = 0;
            if (low_run > max_low) max_low = low_run;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Drives one 8N1 frame with exact fractional bit edges; optionally pulses rst at cycle abort_at.
    task automatic send_frame(input logic [7:0] d, input logic stop, input int abort_at);
        logic [9:0] f;
        int k;
        f = {stop, d, 1'b0};
        for (int cyc = 0; cyc < 1041; cyc++) begin
            k = (cyc * 9600) / 1000000;
            rx = f[k];
            if (cyc == abort_at) begin
                rst = 1'b0;
                @(negedge clk);
                rst = 1'b1;
                rx  = 1'b1;
                return;
            end
            @(negedge clk);
        end
    endtask

    typedef struct {
        logic [7:0] data;
        logic       stop;
        int         exp_done;
        logic [7:0] exp_dout;
        int         exp_ferr;
    } vec_t;

    vec_t vecs[6];

    initial begin
        int d0, f0;

        vecs[0] = '{8'h55, 1'b1, 1, 8'h55, 0};
        vecs[1] = '{8'hA3, 1'b1, 1, 8'hA3, 0};
        vecs[2] = '{8'h00, 1'b1, 1, 8'h00, 0};
        vecs[3] = '{8'h3C, 1'b0, 0, 8'h00, 1};
        vecs[4] = '{8'h81, 1'b1, 1, 8'h81, 0};
        vecs[5] = '{8'hFF, 1'b1, 1, 8'hFF, 0};

        rst = 1'b0;
        rx  = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("reset_dout", 32'(doutrx), 32'h0);
        check("reset_done", 32'(donerx), 32'h0);
        check("reset_ferr", 32'(frame_err), 32'h0);
        check("reset_brk",  32'(brk), 32'h0);
        check("reset_busy", 32'(busy), 32'h0);
        repeat (20) @(negedge clk);

        for (int i = 0; i < 6; i++) begin
            d0 = done_cnt;
            f0 = ferr_cnt;
            send_frame(vecs[i].data, vecs[i].stop, -1);
            rx = 1'b1;
            repeat (210) @(negedge clk);
            check($sformatf("vec%0d_done", i), 32'(done_cnt - d0), 32'(vecs[i].exp_done));
            check($sformatf("vec%0d_dout", i), 32'(doutrx), 32'(vecs[i].exp_dout));
            check($sformatf("vec%0d_ferr", i), 32'(ferr_cnt - f0), 32'(vecs[i].exp_ferr));
            check($sformatf("vec%0d_brk", i), 32'(brk), 32'h0);
            check($sformatf("vec%0d_busy", i), 32'(busy), 32'h0);
        end

        // Back-to-back frames, no idle between stop and next start.
        d0 = done_cnt;
        low_run = 0;
        max_low = 0;
        watch = 1'b1;
        send_frame(8'hFF, 1'b1, -1);
        send_frame(8'h01, 1'b1, -1);
        watch = 1'b0;
        rx = 1'b1;
        repeat (210) @(negedge clk);
        check("b2b_done", 32'(done_cnt - d0), 32'd2);
        check("b2b_first", 32'(rxq[rxq.size() - 2]), 32'hFF);
        check("b2b_second", 32'(rxq[rxq.size() - 1]), 32'h01);
        check("b2b_busy_gap_le_bit", 32'(max_low <= 105), 32'd1);

        // 30-clk glitch on idle line.
        d0 = done_cnt;
        f0 = ferr_cnt;
        rx = 1'b0;
        repeat (10) @(negedge clk);
        check("glitch_busy_high", 32'(busy), 32'd1);
        repeat (20) @(negedge clk);
        rx = 1'b1;
        repeat (210) @(negedge clk);
        check("glitch_done", 32'(done_cnt - d0), 32'd0);
        check("glitch_ferr", 32'(ferr_cnt - f0), 32'd0);
        check("glitch_busy_low", 32'(busy), 32'd0);

        // Line held low for 20 bit times.
        d0 = done_cnt;
        f0 = ferr_cnt;
        rx = 1'b0;
        repeat (2083) @(negedge clk);
        check("break_brk_high", 32'(brk), 32'd1);
        check("break_busy_high", 32'(busy), 32'd1);
        check("break_ferr", 32'(ferr_cnt - f0), 32'd1);
        check("break_done", 32'(done_cnt - d0), 32'd0);
        rx = 1'b1;
        repeat (5) @(negedge clk);
        check("break_brk_low", 32'(brk), 32'd0);
        check("break_busy_low", 32'(busy), 32'd0);
        repeat (100) @(negedge clk);
        d0 = done_cnt;
        send_frame(8'h7E, 1'b1, -1);
        repeat (210) @(negedge clk);
        check("after_break_rx", 32'(done_cnt - d0) << 8 | 32'(doutrx), 32'h17E);

        // Reset pulse in the middle of the 4th data bit.
        d0 = done_cnt;
        f0 = ferr_cnt;
        send_frame(8'h96, 1'b1, 469);
        repeat (1200) @(negedge clk);
        check("abort_done", 32'(done_cnt - d0), 32'd0);
        check("abort_ferr", 32'(ferr_cnt - f0), 32'd0);
        check("abort_dout", 32'(doutrx), 32'h0);
        check("abort_busy", 32'(busy), 32'd0);
        send_frame(8'hC3, 1'b1, -1);
        repeat (210) @(negedge clk);
        check("after_abort_done", 32'(done_cnt - d0), 32'd1);
        check("after_abort_dout", 32'(doutrx), 32'hC3);

        check("done_ferr_exclusive", 32'(both_cnt), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
